// File: rtl/axis_stream_fifo_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tready) shared by both sides of the FIFO.
// The master modport drives data/valid; the slave modport drives ready.
interface axis_stream_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_stream_fifo.sv
// First-word-fall-through AXI-Stream FIFO placed after the 2:1 stream mux.
// Exposes occupancy and an almost-full flag for the upstream select policy.
module axis_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_stream_fifo_if.slave        s_axis,
  axis_stream_fifo_if.master       m_axis,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]           wr_ptr_reg, wr_ptr_next;
  logic [AW:0]           rd_ptr_reg, rd_ptr_next;
  logic [AW:0]           count_next;
  logic                  s_tready_reg;
  logic                  wr_en, rd_en, m_tvalid;
  logic [DATA_WIDTH-1:0] head_data, m_tdata;

  // Pointers carry an extra MSB, so their difference is the exact occupancy 0..DEPTH.
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign m_tvalid = (count != '0);
  assign wr_en    = s_axis.tvalid && s_tready_reg;
  assign rd_en    = m_tvalid && m_axis.tready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_en};
    rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_en};
    count_next  = wr_ptr_next - rd_ptr_next;
  end

  // Ready is registered from the next occupancy, so a read while full frees a slot one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      s_tready_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      s_tready_reg <= (count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= s_axis.tdata;
    end
  end

  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  // Head data is forced to zero while empty so stale or uninitialised entries never show.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_head_gate
      assign m_tdata[gi] = head_data[gi] & m_tvalid;
    end
  endgenerate

  assign s_axis.tready = s_tready_reg;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tvalid = m_tvalid;
  assign almost_full   = (count >= CW'(AF_THRESH));
endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo: reset, single beat, fill/full, wrap streaming, mid-stream reset.
module tb_axis_stream_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] count;
  logic       almost_full;

  int n_compared = 0;
  int n_mismatched = 0;

  axis_stream_fifo_if #(.DATA_WIDTH(DW)) up_if ();
  axis_stream_fifo_if #(.DATA_WIDTH(DW)) dn_if ();

  axis_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axis      (up_if.slave),
    .m_axis      (dn_if.master),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor: no write accepted while full, no read accepted while empty.
  always @(negedge clk) begin
    if (rst_n) begin
      check("no_wr_when_full", 64'(up_if.tvalid && up_if.tready && (count == 5'd16)), 64'd0);
      check("no_rd_when_empty", 64'(dn_if.tvalid && dn_if.tready && (count == 5'd0)), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_data;
    rst_n = 1'b0;
    up_if.tdata = '0;
    up_if.tvalid = 1'b0;
    dn_if.tready = 1'b0;

    // Reset release
    repeat (3) step();
    check("rst_s_tready", 64'(up_if.tready), 64'd0);
    check("rst_m_tvalid", 64'(dn_if.tvalid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_m_tdata", 64'(dn_if.tdata), 64'd0);
    check("rst_af", 64'(almost_full), 64'd0);
    rst_n = 1'b1;
    step();
    check("rel_s_tready", 64'(up_if.tready), 64'd1);
    check("rel_count", 64'(count), 64'd0);
    $display("txn reset_release done");

    // Single beat
    up_if.tdata = 32'hDEADBEEF;
    up_if.tvalid = 1'b1;
    step();
    up_if.tvalid = 1'b0;
    check("one_m_tvalid", 64'(dn_if.tvalid), 64'd1);
    check("one_m_tdata", 64'(dn_if.tdata), 64'hDEADBEEF);
    check("one_count", 64'(count), 64'd1);
    dn_if.tready = 1'b1;
    step();
    dn_if.tready = 1'b0;
    check("one_rd_count", 64'(count), 64'd0);
    check("one_rd_m_tvalid", 64'(dn_if.tvalid), 64'd0);
    check("one_rd_m_tdata", 64'(dn_if.tdata), 64'd0);
    $display("txn single_beat 0xdeadbeef done");

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      up_if.tdata = 32'(i);
      up_if.tvalid = 1'b1;
      step();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_af", 64'(almost_full), 64'((i + 1) >= 12));
      check("fill_s_tready", 64'(up_if.tready), 64'((i + 1) < 16));
      $display("txn fill write 0x%0h count=%0d", i, count);
    end
    up_if.tdata = 32'h99;
    step();
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_head", 64'(dn_if.tdata), 64'h0);
    $display("txn 17th beat offered while full");

    // Full with simultaneous read
    up_if.tdata = 32'h10;
    dn_if.tready = 1'b1;
    check("full_rd_head", 64'(dn_if.tdata), 64'h0);
    step();
    dn_if.tready = 1'b0;
    check("full_rd_count", 64'(count), 64'd15);
    check("full_rd_s_tready", 64'(up_if.tready), 64'd1);
    check("full_rd_next_head", 64'(dn_if.tdata), 64'h1);
    step();
    up_if.tvalid = 1'b0;
    check("refill_count", 64'(count), 64'd16);
    check("refill_s_tready", 64'(up_if.tready), 64'd0);
    $display("txn full read/write collision done");

    // Drain and confirm ordering 0x01..0x0F then 0x10
    dn_if.tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_data = (j < 15) ? 32'(j + 1) : 32'h10;
      check("drain_data", 64'(dn_if.tdata), 64'(exp_data));
      step();
      $display("txn drain read expect 0x%0h", exp_data);
    end
    check("drain_count", 64'(count), 64'd0);

    // Streaming through pointer wrap
    up_if.tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      up_if.tdata = 32'h100 + 32'(i);
      step();
      check("stream_count", 64'(count), 64'd1);
      check("stream_data", 64'(dn_if.tdata), 64'(32'h100 + 32'(i)));
      $display("txn stream beat 0x%0h", 32'h100 + 32'(i));
    end
    up_if.tvalid = 1'b0;
    step();
    dn_if.tready = 1'b0;
    check("stream_end_count", 64'(count), 64'd0);
    check("stream_end_m_tvalid", 64'(dn_if.tvalid), 64'd0);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) begin
      up_if.tdata = 32'hA0 + 32'(i);
      up_if.tvalid = 1'b1;
      step();
    end
    up_if.tvalid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_m_tvalid", 64'(dn_if.tvalid), 64'd0);
    check("async_rst_s_tready", 64'(up_if.tready), 64'd0);
    check("async_rst_m_tdata", 64'(dn_if.tdata), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_s_tready", 64'(up_if.tready), 64'd1);
    up_if.tdata = 32'hC0;
    up_if.tvalid = 1'b1;
    step();
    up_if.tdata = 32'hC1;
    check("post_rst_first", 64'(dn_if.tdata), 64'hC0);
    step();
    up_if.tvalid = 1'b0;
    dn_if.tready = 1'b1;
    step();
    dn_if.tready = 1'b0;
    check("post_rst_second", 64'(dn_if.tdata), 64'hC1);
    check("post_rst_count", 64'(count), 64'd1);
    $display("txn mid-stream reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/axis_stream_fifo.md
Name: axis_stream_fifo

Overview:
- Synchronous AXI-Stream FIFO placed directly downstream of the 2:1 AXI-Stream mux output (tdata_out/tvalid_out/tready_out).
- Decouples the selected source from downstream backpressure; absorbs up to DEPTH beats.
- First-word-fall-through: head entry is presented on the master side without a read request.
- Exposes occupancy and an almost-full flag for upstream arbitration (sel policy) logic.

Parameters:
- DATA_WIDTH, 32, width of tdata on both sides.
- DEPTH, 16, number of entries; power of two, >= 2.
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk externally.
- s_tdata  input  DATA_WIDTH  write data, driven from the mux tdata_out.
- s_tvalid  input  1  write valid, driven from the mux tvalid_out.
- s_tready  output  1  FIFO can accept; drives the mux tready_out.
- m_tdata  output  DATA_WIDTH  head-of-FIFO data.
- m_tvalid  output  1  FIFO non-empty.
- m_tready  input  1  downstream accepts.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_THRESH.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, s_tready=0, m_tvalid=0, m_tdata=0, almost_full=0. Memory contents are not reset.
- s_tready is registered. It rises on the first clk edge after rst_n deasserts. Afterwards it is registered as (count_next < DEPTH).
- Write on s_tvalid && s_tready: store s_tdata at wr_ptr, wr_ptr += 1 modulo DEPTH. Pointers carry one extra MSB for full/empty disambiguation.
- Read on m_tvalid && m_tready: rd_ptr += 1 modulo DEPTH.
- count_next = count + write - read. A simultaneous write and read leaves count unchanged.
- m_tvalid = (count != 0), registered via count.
- m_tdata = mem[rd_ptr] when m_tvalid=1, else 0. No X leakage.
- Latency: a beat written at edge N appears on m_tvalid/m_tdata after edge N. No same-cycle bypass.
- Full (count=DEPTH): s_tready=0. A read in that cycle does not allow a same-cycle write; s_tready rises one cycle after the read.
- Empty (count=0): m_tvalid=0. A write in that cycle is not readable until the next cycle.
- Handshake rules:
  - Data ordering is strict FIFO; no beat is dropped or duplicated.
  - m_tvalid, once high, stays high and m_tdata stays stable until m_tready is sampled high (AXI-Stream rule).
  - s_tvalid low with s_tready high writes nothing.
- Pointer wrap: modulo DEPTH at the index bits; the extra MSB toggles on each wrap.
- almost_full is combinational from the registered count.
- Reset mid-operation: all contents are discarded. Outputs return to their reset values immediately, asynchronously.
- Overflow and underflow are impossible by construction. Assertions in the bench check that writes never occur while full and reads never occur while empty.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles, then release -> s_tready=0 during reset and 1 one cycle after; m_tvalid=0; count=0; m_tdata=0.
- Single beat: write 0xDEADBEEF with m_tready=0 -> next cycle m_tvalid=1, m_tdata=0xDEADBEEF, count=1. Raise m_tready -> beat accepted, count=0, m_tvalid=0, m_tdata=0.
- Fill to full: with m_tready=0, write 0x00..0x0F (16 beats) -> almost_full=1 once count=12; s_tready=0 once count=16. A 17th s_tvalid is ignored.
- Full with simultaneous read: from full, assert m_tready one cycle with s_tvalid=1 and data 0x10 -> 0x00 read, 0x10 not written that cycle. s_tready=1 next cycle; 0x10 accepted then; count returns to 16.
- Streaming and wrap: m_tready=1 and s_tvalid=1 continuously for 40 beats of an incrementing pattern -> output sequence matches input in order. Count stays <= 1 in steady state. Pointers wrap twice with no loss.
- Mid-stream reset: with count=5, pulse rst_n low asynchronously between edges -> count=0, m_tvalid=0, s_tready=0 immediately. After release, the first new beat written is the first one read out.
